// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, frame state encoding and baud divisor table
package uart_pkg;

  localparam int SAMPLES_PER_BIT = 16;
  localparam int BAUD_CNT_W      = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  typedef logic [7:0][BAUD_CNT_W-1:0] div_tab_t;

  function automatic int baud_rate(input logic [2:0] sel);
    case (sel)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Rounded clk/(16*baud): adding half the denominator before dividing.
  function automatic logic [BAUD_CNT_W-1:0] baud_div(input int clk_hz, input logic [2:0] sel);
    int rate;
    int div;
    rate = baud_rate(sel);
    div  = (clk_hz + 8 * rate) / (16 * rate);
    return div[BAUD_CNT_W-1:0];
  endfunction

  function automatic div_tab_t baud_div_table(input int clk_hz);
    div_tab_t t;
    for (int s = 0; s < 8; s++) begin
      t[s[2:0]] = baud_div(clk_hz, s[2:0]);
    end
    return t;
  endfunction

endpackage

// File: rtl/baud_controller_transmitter.sv
// rtl/baud_controller_transmitter.sv - one Tx_sample_ENABLE pulse per 1/16 bit period
module baud_controller_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] baud_select,
  output logic       Tx_sample_ENABLE
);

  localparam div_tab_t DIV_TAB = baud_div_table(CLK_FREQ_HZ);

  logic [BAUD_CNT_W-1:0] r_cnt;
  logic [BAUD_CNT_W-1:0] w_div_m1;
  logic                  w_wrap;

  assign w_div_m1 = DIV_TAB[baud_select] - BAUD_CNT_W'(1);
  assign w_wrap   = (r_cnt == w_div_m1);

  // Held at zero while disabled so every frame starts a fresh sample period.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + BAUD_CNT_W'(1);
    end
  end

  assign Tx_sample_ENABLE = enable && w_wrap;

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8E1/8O1 UART frame serialiser with Tx_WR/Tx_BUSY handshake
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] Tx_baud_select,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  tx_state_e  r_state, w_state_nxt;
  logic [3:0] r_sample_cnt, w_sample_cnt_nxt;
  logic [2:0] r_bit_idx, w_bit_idx_nxt;
  logic [7:0] r_shreg, w_shreg_nxt;
  logic       r_parity, w_parity_nxt;
  logic [2:0] r_baud_sel, w_baud_sel_nxt;
  logic       r_txd, w_txd_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       w_sample_en;
  logic       w_bit_end;

  baud_controller_transmitter #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_baud (
    .clk             (clk),
    .reset           (reset),
    .enable          (r_busy),
    .baud_select     (r_baud_sel),
    .Tx_sample_ENABLE(w_sample_en)
  );

  assign w_bit_end = w_sample_en && (r_sample_cnt == 4'(SAMPLES_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= '0;
      r_bit_idx    <= '0;
      r_shreg      <= 8'hFF;
      r_parity     <= 1'b0;
      r_baud_sel   <= '0;
      r_txd        <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sample_cnt <= w_sample_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shreg      <= w_shreg_nxt;
      r_parity     <= w_parity_nxt;
      r_baud_sel   <= w_baud_sel_nxt;
      r_txd        <= w_txd_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // TxD is computed one cycle ahead so the line level always comes from a flop.
  always_comb begin
    w_state_nxt      = r_state;
    w_sample_cnt_nxt = w_sample_en ? r_sample_cnt + 4'd1 : r_sample_cnt;
    w_bit_idx_nxt    = r_bit_idx;
    w_shreg_nxt      = r_shreg;
    w_parity_nxt     = r_parity;
    w_baud_sel_nxt   = r_baud_sel;
    w_txd_nxt        = r_txd;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_txd_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
        if (Tx_WR && Tx_EN) begin
          w_state_nxt      = ST_START;
          w_shreg_nxt      = Tx_DATA;
          w_parity_nxt     = (^Tx_DATA) ^ PARITY_ODD;
          w_baud_sel_nxt   = Tx_baud_select;
          w_sample_cnt_nxt = '0;
          w_bit_idx_nxt    = '0;
          w_txd_nxt        = 1'b0;
          w_busy_nxt       = 1'b1;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt   = ST_DATA;
          w_bit_idx_nxt = '0;
          w_txd_nxt     = r_shreg[0];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_PARITY;
            w_txd_nxt   = r_parity;
          end else begin
            w_shreg_nxt   = {1'b1, r_shreg[7:1]};
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_txd_nxt     = r_shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_txd_nxt   = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = ST_IDLE;
          w_txd_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_txd_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase

    if (!Tx_EN) begin
      w_state_nxt      = ST_IDLE;
      w_sample_cnt_nxt = '0;
      w_txd_nxt        = 1'b1;
      w_busy_nxt       = 1'b0;
      w_done_nxt       = 1'b0;
    end
  end

  assign TxD     = r_txd;
  assign Tx_BUSY = r_busy;
  assign Tx_DONE = r_done;

endmodule
